// File: rtl/lfsr_rng_arbiter.sv
// lfsr_rng_arbiter: one 8-bit Fibonacci LFSR shared by two requesters.
// Each served request advances the register STEPS times. The resulting byte
// is returned on rnd with a one-cycle ack to the owner of the operation.
// Simultaneous requests are arbitrated round-robin.
module lfsr_rng_arbiter #(
  parameter int unsigned STEPS    = 8,
  parameter logic [7:0]  SEED_RST = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       seed_we,
  input  logic [7:0] seed,
  input  logic       req0,
  input  logic       req1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rnd,
  output logic       busy,
  output logic       owner
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  // cnt counts completed steps; the step that reaches STEPS is taken when cnt == STEPS-1
  localparam logic [7:0] LAST_CNT = 8'(STEPS - 1);

  // One Fibonacci step: feedback from taps 4,3,2,0 enters at the MSB
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[4] ^ v[3] ^ v[2] ^ v[0], v[7:1]};
  endfunction

  // A zero seed would lock the register up, so it is replaced by 8'h01
  function automatic logic [7:0] seed_guard(input logic [7:0] s);
    return (s == 8'h00) ? 8'h01 : s;
  endfunction

  state_t     state_q, state_d;
  logic [7:0] cnt_q,   cnt_d;
  logic [7:0] lfsr_q,  lfsr_d;
  logic [7:0] rnd_q,   rnd_d;
  logic       ack0_q,  ack0_d;
  logic       ack1_q,  ack1_d;
  logic       busy_q,  busy_d;
  logic       owner_q, owner_d;
  // last_q: requester served most recently; the other one wins a tie
  logic       last_q,  last_d;

  // Next-state logic: seed load overrides the FSM, otherwise arbitrate / shift / acknowledge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    rnd_d   = rnd_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    owner_d = owner_q;
    last_d  = last_q;

    if (seed_we) begin
      lfsr_d  = seed_guard(seed);
      state_d = ST_IDLE;
      cnt_d   = 8'd0;
      // A byte already delivered in the ACK cycle still counts as served
      if (state_q == ST_ACK) begin
        last_d = owner_q;
      end else begin
        last_d = last_q;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req0 || req1) begin
            state_d = ST_SHIFT;
            cnt_d   = 8'd0;
            if (req0 && req1) begin
              owner_d = ~last_q;
            end else begin
              owner_d = req1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SHIFT: begin
          lfsr_d = lfsr_step(lfsr_q);
          cnt_d  = 8'(cnt_q + 8'd1);
          if (cnt_q == LAST_CNT) begin
            state_d = ST_ACK;
            rnd_d   = lfsr_step(lfsr_q);
            ack0_d  = ~owner_q;
            ack1_d  = owner_q;
          end else begin
            state_d = ST_SHIFT;
          end
        end
        ST_ACK: begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
          last_d  = owner_q;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      lfsr_q  <= SEED_RST;
      rnd_q   <= 8'h00;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      rnd_q   <= rnd_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign ack0  = ack0_q;
  assign ack1  = ack1_q;
  assign rnd   = rnd_q;
  assign busy  = busy_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Testbench for lfsr_rng_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a transaction-level model.
module tb_lfsr_rng_arbiter;

  localparam int         STEPS    = 8;
  localparam logic [7:0] SEED_RST = 8'h01;

  logic       clk = 1'b0;
  logic       rst, seed_we, req0, req1;
  logic [7:0] seed;
  logic       ack0, ack1, busy, owner;
  logic [7:0] rnd;

  always #5 clk = ~clk;

  lfsr_rng_arbiter #(.STEPS(STEPS), .SEED_RST(SEED_RST)) dut (
    .clk(clk), .rst(rst), .seed_we(seed_we), .seed(seed),
    .req0(req0), .req1(req1), .ack0(ack0), .ack1(ack1),
    .rnd(rnd), .busy(busy), .owner(owner)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model: m_t = cycles into the current operation (0 = idle, STEPS+1 = ack cycle).
  // The LFSR value is only observable through the byte a grant will produce,
  // so the model advances it by STEPS at the grant and lets seed/reset overwrite it.
  int         m_t;
  logic [7:0] m_lfsr, m_rnd, m_res;
  logic       m_owner, m_last;

  function automatic logic [7:0] adv(input logic [7:0] v, input int n);
    logic [7:0] x;
    x = v;
    for (int i = 0; i < n; i++) x = {x[4] ^ x[3] ^ x[2] ^ x[0], x[7:1]};
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_lfsr = SEED_RST; m_t = 0; m_rnd = 8'h00; m_owner = 1'b0; m_last = 1'b1;
    end else if (seed_we) begin
      if (m_t == STEPS + 1) m_last = m_owner;
      m_lfsr = (seed == 8'h00) ? 8'h01 : seed;
      m_t = 0;
    end else if (m_t == 0) begin
      if (req0 || req1) begin
        m_owner = (req0 && req1) ? ~m_last : req1;
        m_res   = adv(m_lfsr, STEPS);
        m_lfsr  = m_res;
        m_t     = 1;
      end
    end else if (m_t < STEPS + 1) begin
      m_t++;
      if (m_t == STEPS + 1) m_rnd = m_res;
    end else begin
      m_last = m_owner;
      m_t = 0;
    end
  endtask

  task automatic compare_all();
    check("ack0",    32'(ack0),  32'((m_t == STEPS + 1) && !m_owner));
    check("ack1",    32'(ack1),  32'((m_t == STEPS + 1) && m_owner));
    check("rnd",     32'(rnd),   32'(m_rnd));
    check("busy",    32'(busy),  32'(m_t != 0));
    check("owner",   32'(owner), 32'(m_owner));
    check("ack_excl", 32'(ack0 & ack1), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Advance until an ack appears; an expired budget is a failed comparison
  task automatic wait_ack(output int at, output logic who);
    at = -1; who = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (ack0 || ack1) begin
        at = cyc; who = ack1;
        return;
      end
    end
    check("ack_timeout", 32'd0, 32'd1);
  endtask

  int         g, at, at2, s, idle;
  logic       who;
  logic [7:0] vals [4];
  logic       whos [4];

  initial begin
    rst = 1'b1; seed_we = 1'b0; seed = 8'h00; req0 = 1'b0; req1 = 1'b0;
    m_t = 0; m_lfsr = SEED_RST; m_rnd = 8'h00; m_res = 8'h00; m_owner = 1'b0; m_last = 1'b1;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    check("rst_ack0", 32'(ack0), 32'd0);
    check("rst_ack1", 32'(ack1), 32'd0);
    check("rst_rnd",  32'(rnd),  32'h00);
    check("rst_busy", 32'(busy), 32'd0);

    // Single requester, held: first and second bytes, latency and idle gap
    req0 = 1'b1;
    tick(); g = cyc;
    check("t1_grant_busy", 32'(busy), 32'd1);
    wait_ack(at, who);
    check("t1_latency_edges", 32'(at - g), 32'(STEPS));
    check("t1_rnd", 32'(rnd), 32'h71);
    check("t1_who", 32'(who), 32'd0);
    idle = 0; at2 = -1;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (!busy) idle++;
      if (ack0 || ack1) begin at2 = cyc; break; end
    end
    check("t1_period", 32'(at2 - at), 32'(STEPS + 2));
    check("t1_rnd2", 32'(rnd), 32'hA4);
    check("t1_idle_gap", 32'(idle), 32'd1);
    req0 = 1'b0;

    // Both requesters held: alternating service
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_ack(at, who);
      whos[i] = who; vals[i] = rnd;
    end
    for (int i = 0; i < 4; i++) check("t2_order", 32'(whos[i]), 32'(i % 2));
    check("t2_val0", 32'(vals[0]), 32'h71);
    check("t2_val1", 32'(vals[1]), 32'hA4);
    req0 = 1'b0; req1 = 1'b0;

    // Zero seed is replaced by 8'h01
    do_reset();
    seed_we = 1'b1; seed = 8'h00;
    tick();
    seed_we = 1'b0;
    req1 = 1'b1;
    wait_ack(at, who);
    check("t3_who", 32'(who), 32'd1);
    check("t3_rnd", 32'(rnd), 32'h71);
    req1 = 1'b0;

    // Seed load aborts a SHIFT at the 4th step
    do_reset();
    req0 = 1'b1;
    tick();
    tick(); tick(); tick();
    seed_we = 1'b1; seed = 8'h01;
    tick(); s = cyc;
    seed_we = 1'b0;
    check("t4_abort_busy", 32'(busy), 32'd0);
    wait_ack(at, who);
    check("t4_latency_edges", 32'(at - s), 32'(STEPS + 1));
    check("t4_who", 32'(who), 32'd0);
    check("t4_rnd", 32'(rnd), 32'h71);
    req0 = 1'b0;

    // Reset during SHIFT
    do_reset();
    req0 = 1'b1;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_acks", 32'({ack0, ack1}), 32'd0);
    check("t5_rnd",  32'(rnd), 32'h00);
    check("t5_owner", 32'(owner), 32'd0);
    wait_ack(at, who);
    check("t5_rnd_after", 32'(rnd), 32'h71);
    req0 = 1'b0;

    // Randomized traffic, checked every cycle by compare_all
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      rst     = ($urandom_range(0, 299) == 0);
      seed_we = ($urandom_range(0, 59) == 0);
      seed    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom());
      if ($urandom_range(0, 4) == 0) req0 = ~req0;
      if ($urandom_range(0, 4) == 0) req1 = ~req1;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lfsr_rng_arbiter.md
Name: lfsr_rng_arbiter

Overview:
Owns one 8-bit Fibonacci LFSR and time-shares it between two requesters that each need a fresh random byte. The block holds the seed, advances the register a fixed number of steps per request, returns the byte with a one-cycle acknowledge, and arbitrates simultaneous requests round-robin. It sits between the LFSR datapath used by the lab designs and any consumers that need random bytes, such as dice, LED patterns or test stimulus.

Parameters:
STEPS, 8, number of LFSR shifts per served request; range 1..255.
SEED_RST, 8'h01, LFSR value after reset; must be non-zero.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  synchronous reset, active-high.
seed_we  input  1  load the seed this cycle.
seed  input  8  seed value, used when seed_we=1.
req0  input  1  level request from requester 0.
req1  input  1  level request from requester 1.
ack0  output  1  one-cycle pulse: rnd is valid for requester 0.
ack1  output  1  one-cycle pulse: rnd is valid for requester 1.
rnd  output  8  random byte; holds its last delivered value between acks.
busy  output  1  high in SHIFT and ACK states.
owner  output  1  requester currently being served; holds its last value when idle.

Behaviour:
- LFSR step (the only state change on lfsr): lfsr_next = {lfsr[4]^lfsr[3]^lfsr[2]^lfsr[0], lfsr[7:1]}.
- Reset, when rst=1 at an edge:
  - lfsr=SEED_RST, state=IDLE, cnt=0.
  - ack0=ack1=0, rnd=8'h00, busy=0, owner=0.
  - Round-robin pointer favours req0.
  - Reset takes priority over every other input and aborts any operation in progress.
- Seed load: seed_we=1 sets lfsr=seed, or 8'h01 if seed==0 (all-zero lock-up guard).
  - seed_we is accepted in any state and returns the FSM to IDLE with cnt=0 and no ack.
  - An aborted requester still holds req and is re-arbitrated normally.
  - seed_we has priority over requests and shifting in the same cycle.
- FSM states: IDLE, SHIFT, ACK.
  - IDLE:
    - If any req is high, grant one requester, set owner, cnt=0, go to SHIFT.
    - Only one requester high: it wins.
    - Both high: the requester not served last wins; after reset req0 wins first.
    - No shift occurs on the grant edge.
  - SHIFT:
    - Each edge applies one LFSR step and increments cnt.
    - On the edge that performs step number STEPS: go to ACK, copy lfsr_next into rnd, set ack[owner]=1.
    - Requests are not re-sampled in SHIFT; dropping req mid-SHIFT does not cancel the operation.
  - ACK:
    - Exactly one cycle with ack[owner]=1. Next edge: ack cleared, rr pointer updated to the other requester, go to IDLE.
- Latency: a req sampled high in IDLE at edge E0 gives ack high in the cycle after edge E0+STEPS, i.e. STEPS+1 cycles later.
  - A requester holding req continuously is re-served after one IDLE cycle.
  - Period per byte is STEPS+2 cycles.
- ack0 and ack1 are never high together. ack is registered, with no combinational path from req.
- busy=1 in SHIFT and ACK, 0 in IDLE.
- Requesters must drop req in the ack cycle if they want only one byte. req still high in the following IDLE cycle is a new request.

Test Plan:
- Reset, then req0=1 held until ack0 -> grant at first edge; ack0 high exactly 9 cycles after req0 is sampled; rnd=8'h71; ack1 stays 0.
- req0 held continuously after reset -> second ack0 10 cycles after the first; rnd=8'hA4; busy low exactly one cycle between the two operations.
- req0 and req1 both held high from reset -> ack order 0,1,0,1; values 8'h71, 8'hA4, then the continuing sequence; acks never overlap.
- seed_we=1 with seed=8'h00 in IDLE, then req1 -> lfsr forced to 8'h01; ack1 gives rnd=8'h71.
- During SHIFT of a req0 operation, pulse seed_we with seed=8'h01 at the 4th step -> no ack that operation; FSM returns to IDLE; with req0 still high, next ack0 gives rnd=8'h71 exactly 10 cycles after the seed edge.
- rst asserted during SHIFT -> next cycle all outputs 0, busy=0; the following request gives 8'h71 again.
